// File: rtl/fpga_clb_io_tile.sv
// Leaf tile of the FPGA array: one 4-input LUT logic block with an optional
// output flip-flop, plus two bidirectional pad I/O blocks.
// All behaviour is set by a 27-bit serial configuration chain.
module fpga_clb_io_tile (
    input  logic clk,
    input  logic rst,
    input  logic cfg_en,
    input  logic cfg_din,
    output logic cfg_dout,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    input  logic K,
    output logic X,
    output logic Y,
    inout  wire  PIN1,
    inout  wire  PIN2,
    input  logic OUT1,
    input  logic OUT2,
    input  logic TS1,
    input  logic TS2,
    output logic IN1,
    output logic IN2
);

    localparam int CFG_W = 27;

    // Layout of the configuration chain, MSB (cfg[26]) first.
    typedef struct packed {
        logic        in_reg2;
        logic        out_reg2;
        logic        out_inv2;
        logic        oe_en2;
        logic        in_reg1;
        logic        out_reg1;
        logic        out_inv1;
        logic        oe_en1;
        logic        y_sel;
        logic        x_sel;
        logic        k_en;
        logic [15:0] lut;
    } cfg_t;

    cfg_t cfg_q, cfg_d;
    logic q_q, q_d;          // CLB flip-flop
    logic od1_q, od1_d;      // IOB output registers
    logic od2_q, od2_d;
    logic in1_q, in1_d;      // IOB input registers
    logic in2_q, in2_d;

    logic f;
    logic od1, od2;
    logic pad1_data, pad2_data;
    logic drive1, drive2;

    // CLB function generator and output select.
    assign f = cfg_q.lut[{D, C, B, A}];
    assign X = cfg_q.x_sel ? q_q : f;
    assign Y = cfg_q.y_sel ? q_q : f;

    // IOB output path: optional inversion, optional register, tristate pad.
    assign od1       = cfg_q.out_inv1 ? ~OUT1 : OUT1;
    assign od2       = cfg_q.out_inv2 ? ~OUT2 : OUT2;
    assign pad1_data = cfg_q.out_reg1 ? od1_q : od1;
    assign pad2_data = cfg_q.out_reg2 ? od2_q : od2;
    // Pads are released while the chain shifts so half-loaded bits never drive.
    assign drive1    = cfg_q.oe_en1 & ~TS1 & ~cfg_en;
    assign drive2    = cfg_q.oe_en2 & ~TS2 & ~cfg_en;
    assign PIN1      = drive1 ? pad1_data : 1'bz;
    assign PIN2      = drive2 ? pad2_data : 1'bz;

    // IOB input path: pad value, optionally registered; sees own drive as loopback.
    assign IN1 = cfg_q.in_reg1 ? in1_q : PIN1;
    assign IN2 = cfg_q.in_reg2 ? in2_q : PIN2;

    assign cfg_dout = cfg_q.in_reg2;

    // Next-state: shift the chain while configuring, otherwise update user registers.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        cfg_d = cfg_q;
        q_d   = q_q;
        od1_d = od1_q;
        od2_d = od2_q;
        in1_d = in1_q;
        in2_d = in2_q;
        if (cfg_en) begin
            cfg_d = cfg_t'({cfg_q[CFG_W-2:0], cfg_din});
        end else begin
            if (!cfg_q.k_en || K) begin
                q_d = f;
            end
            od1_d = od1;
            od2_d = od2;
            in1_d = PIN1;
            in2_d = PIN2;
        end
    end

    // State registers; synchronous reset has priority over configuration.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            cfg_q <= '0;
            q_q   <= 1'b0;
            od1_q <= 1'b0;
            od2_q <= 1'b0;
            in1_q <= 1'b0;
            in2_q <= 1'b0;
        end else begin
            cfg_q <= cfg_d;
            q_q   <= q_d;
            od1_q <= od1_d;
            od2_q <= od2_d;
            in1_q <= in1_d;
            in2_q <= in2_d;
        end
    end

endmodule

// File: tb/tb_fpga_clb_io_tile.sv
// Scoreboard bench for fpga_clb_io_tile: expectations are queued as stimulus is
// applied and compared once the tile output is due. Pads carry pulldowns, so a
// released pad reads 0; high-Z is shown by setting up data that would read 1.
`timescale 1ns/1ps
module tb_fpga_clb_io_tile;

    logic clk = 1'b0;
    logic rst, cfg_en, cfg_din, cfg_dout;
    logic a, b, c, d, k, x, y;
    logic out1, out2, ts1, ts2, in1, in2;
    logic drv1_en, drv1_val, drv2_en, drv2_val;
    wire  pin1, pin2;

    int n_tests = 0;
    int n_fail  = 0;

    assign pin1 = drv1_en ? drv1_val : 1'bz;
    assign pin2 = drv2_en ? drv2_val : 1'bz;
    pulldown pd1 (pin1);
    pulldown pd2 (pin2);

    always #5 clk = ~clk;

    fpga_clb_io_tile dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_en   (cfg_en),
        .cfg_din  (cfg_din),
        .cfg_dout (cfg_dout),
        .A        (a),
        .B        (b),
        .C        (c),
        .D        (d),
        .K        (k),
        .X        (x),
        .Y        (y),
        .PIN1     (pin1),
        .PIN2     (pin2),
        .OUT1     (out1),
        .OUT2     (out2),
        .TS1      (ts1),
        .TS2      (ts2),
        .IN1      (in1),
        .IN2      (in2)
    );

    typedef enum int {SIG_X, SIG_Y, SIG_IN1, SIG_IN2, SIG_PIN1, SIG_PIN2, SIG_DOUT} sig_e;
    typedef struct {
        string tag;
        sig_e  sig;
        logic  exp;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic observe(input sig_e s);
        case (s)
            SIG_X:    return x;
            SIG_Y:    return y;
            SIG_IN1:  return in1;
            SIG_IN2:  return in2;
            SIG_PIN1: return pin1;
            SIG_PIN2: return pin2;
            default:  return cfg_dout;
        endcase
    endfunction

    task automatic expect_sig(input string tag, input sig_e s, input logic e);
        exp_t t;
        t.tag = tag;
        t.sig = s;
        t.exp = e;
        sb_q.push_back(t);
    endtask

    task automatic drain();
        exp_t t;
        while (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            check(t.tag, observe(t.sig), t.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Config word from fields; iob = {in_reg, out_reg, out_inv, oe_en}.
    function automatic logic [26:0] mk(input logic [15:0] lut, input logic k_en,
                                       input logic x_sel, input logic y_sel,
                                       input logic [3:0] iob1, input logic [3:0] iob2);
        return {iob2, iob1, y_sel, x_sel, k_en, lut};
    endfunction

    task automatic load_cfg(input logic [26:0] w);
        cfg_en = 1'b1;
        for (int i = 26; i >= 0; i--) begin
            cfg_din = w[i];
            tick();
        end
        cfg_en  = 1'b0;
        cfg_din = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [26:0] w;
        logic [3:0]  idx;
        logic [7:0]  pat;
        logic        prev;

        // Reset with arbitrary inputs; pads would read 1 if driven.
        rst = 1'b1; cfg_en = 1'b0; cfg_din = 1'b1;
        a = 1'b1; b = 1'b1; c = 1'b1; d = 1'b1; k = 1'b1;
        out1 = 1'b1; out2 = 1'b1; ts1 = 1'b0; ts2 = 1'b0;
        drv1_en = 1'b0; drv1_val = 1'b0; drv2_en = 1'b0; drv2_val = 1'b0;
        tick();
        expect_sig("rst_x", SIG_X, 1'b0);
        expect_sig("rst_y", SIG_Y, 1'b0);
        expect_sig("rst_in1", SIG_IN1, 1'b0);
        expect_sig("rst_in2", SIG_IN2, 1'b0);
        expect_sig("rst_dout", SIG_DOUT, 1'b0);
        expect_sig("rst_pin1_z", SIG_PIN1, 1'b0);
        expect_sig("rst_pin2_z", SIG_PIN2, 1'b0);
        drain();
        rst = 1'b0;

        // Reset in the middle of a shift clears the chain (rst beats cfg_en).
        cfg_en = 1'b1; cfg_din = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; cfg_din = 1'b0;
        for (int i = 0; i < 27; i++) begin
            expect_sig($sformatf("midrst_dout[%0d]", i), SIG_DOUT, 1'b0);
            drain();
            tick();
        end
        cfg_en = 1'b0;

        // Readback: load a word, then shift zeros and watch it come out MSB first.
        w = 27'h5A53C96;
        cfg_en = 1'b1;
        for (int i = 26; i >= 0; i--) begin
            cfg_din = w[i];
            tick();
        end
        cfg_din = 1'b0;
        for (int i = 0; i < 27; i++) begin
            expect_sig($sformatf("readback[%0d]", i), SIG_DOUT, w[26-i]);
            drain();
            tick();
        end
        expect_sig("readback_empty", SIG_DOUT, 1'b0);
        drain();
        cfg_en = 1'b0;

        // CLB combinational: AND4 then XOR4.
        load_cfg(mk(16'h8000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));
        for (int i = 0; i < 16; i++) begin
            idx = i[3:0];
            {d, c, b, a} = idx;
            settle();
            expect_sig($sformatf("and4_x[%0d]", i), SIG_X, idx == 4'hF);
            drain();
        end
        load_cfg(mk(16'h6996, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));
        for (int i = 0; i < 16; i++) begin
            idx = i[3:0];
            {d, c, b, a} = idx;
            settle();
            expect_sig($sformatf("xor4_x[%0d]", i), SIG_X, ^idx);
            expect_sig($sformatf("xor4_y[%0d]", i), SIG_Y, ^idx);
            drain();
        end

        // CLB registered with clock enable: F = A, Y = Q.
        load_cfg(mk(16'hAAAA, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000));
        a = 1'b0; k = 1'b1;
        tick();
        expect_sig("ff_clear", SIG_Y, 1'b0);
        drain();
        a = 1'b1; k = 1'b0;
        tick();
        expect_sig("ff_k0_hold", SIG_Y, 1'b0);
        expect_sig("ff_x_comb", SIG_X, 1'b1);
        drain();
        tick();
        expect_sig("ff_k0_hold2", SIG_Y, 1'b0);
        drain();
        k = 1'b1;
        settle();
        expect_sig("ff_pre_edge", SIG_Y, 1'b0);
        drain();
        tick();
        expect_sig("ff_k1_load", SIG_Y, 1'b1);
        drain();
        a = 1'b0; k = 1'b0;
        tick();
        expect_sig("ff_k0_hold_one", SIG_Y, 1'b1);
        drain();

        // k_en=0: Y follows A one cycle late regardless of K; Q held across config.
        load_cfg(mk(16'hAAAA, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000));
        settle();
        expect_sig("ff_cfg_hold", SIG_Y, 1'b1);
        drain();
        pat  = 8'b1011_0010;
        prev = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = pat[i];
            k = 1'($urandom_range(0, 1));
            settle();
            expect_sig($sformatf("ff_pre[%0d]", i), SIG_Y, prev);
            drain();
            tick();
            expect_sig($sformatf("ff_follow[%0d]", i), SIG_Y, pat[i]);
            drain();
            prev = pat[i];
        end

        // IOB1 output, inverted, combinational.
        load_cfg(mk(16'h0000, 1'b0, 1'b0, 1'b0, 4'b0011, 4'b0000));
        ts1 = 1'b0; out1 = 1'b0;
        settle();
        expect_sig("iob1_pin_inv", SIG_PIN1, 1'b1);
        expect_sig("iob1_loopback", SIG_IN1, 1'b1);
        drain();
        out1 = 1'b1;
        settle();
        expect_sig("iob1_pin_inv0", SIG_PIN1, 1'b0);
        expect_sig("iob1_loopback0", SIG_IN1, 1'b0);
        drain();
        ts1 = 1'b1; out1 = 1'b0;
        settle();
        expect_sig("iob1_ts_z", SIG_PIN1, 1'b0);
        drain();
        drv1_en = 1'b1; drv1_val = 1'b1;
        settle();
        expect_sig("iob1_in_ext1", SIG_IN1, 1'b1);
        drain();
        drv1_val = 1'b0;
        settle();
        expect_sig("iob1_in_ext0", SIG_IN1, 1'b0);
        drain();
        drv1_en = 1'b0;
        ts1 = 1'b0;
        tick();
        cfg_en = 1'b1;
        settle();
        expect_sig("iob1_cfg_z", SIG_PIN1, 1'b0);
        drain();
        cfg_en = 1'b0;
        settle();
        expect_sig("iob1_cfg_release", SIG_PIN1, 1'b1);
        drain();

        // IOB1 registered output: pad changes one edge after OUT1.
        load_cfg(mk(16'h0000, 1'b0, 1'b0, 1'b0, 4'b0111, 4'b0000));
        ts1 = 1'b0; out1 = 1'b0;
        tick();
        expect_sig("iob1_reg_init", SIG_PIN1, 1'b1);
        drain();
        out1 = 1'b1;
        settle();
        expect_sig("iob1_reg_pre", SIG_PIN1, 1'b1);
        drain();
        tick();
        expect_sig("iob1_reg_post", SIG_PIN1, 1'b0);
        drain();
        out1 = 1'b0;
        settle();
        expect_sig("iob1_reg_pre2", SIG_PIN1, 1'b0);
        drain();
        tick();
        expect_sig("iob1_reg_post2", SIG_PIN1, 1'b1);
        drain();
        ts1 = 1'b1;

        // IOB2 registered input; out_reg2 also set so in_reg2 survives one shift edge.
        load_cfg(mk(16'h0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1100));
        drv2_en = 1'b1; drv2_val = 1'b1;
        tick();
        expect_sig("iob2_in_init", SIG_IN2, 1'b1);
        drain();
        drv2_val = 1'b0;
        settle();
        expect_sig("iob2_in_pre_fall", SIG_IN2, 1'b1);
        drain();
        tick();
        expect_sig("iob2_in_fall", SIG_IN2, 1'b0);
        drain();
        drv2_val = 1'b1;
        settle();
        expect_sig("iob2_in_pre_rise", SIG_IN2, 1'b0);
        drain();
        tick();
        expect_sig("iob2_in_rise", SIG_IN2, 1'b1);
        drain();
        drv2_val = 1'b0;
        cfg_en = 1'b1; cfg_din = 1'b0;
        tick();
        expect_sig("iob2_cfg_hold", SIG_IN2, 1'b1);
        drain();
        cfg_en = 1'b0;
        tick();
        expect_sig("iob2_after_cfg", SIG_IN2, 1'b0);
        drain();
        drv2_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
